// File: rtl/steuerung_pkg.sv
// steuerung_pkg: shared constants for the steuerung_param control FSM.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
// Contents: 4-bit state codes (also driven on the status port), trap cause codes,
// and a helper that says which states run the watchdog.
package steuerung_pkg;

    localparam int STATUS_W = 4;

    localparam logic [3:0] S_FETCH      = 4'd0;
    localparam logic [3:0] S_DECODE     = 4'd1;
    localparam logic [3:0] S_ALU1       = 4'd2;
    localparam logic [3:0] S_ALU        = 4'd3;
    localparam logic [3:0] S_WB_JUMP    = 4'd4;
    localparam logic [3:0] S_WB_STORE   = 4'd5;
    localparam logic [3:0] S_WB_LOAD    = 4'd6;
    localparam logic [3:0] S_WB_DEFAULT = 4'd7;
    localparam logic [3:0] S_HALT       = 4'd8;
    localparam logic [3:0] S_TRAP       = 4'd9;

    localparam logic [1:0] URS_NONE  = 2'b00;
    localparam logic [1:0] URS_FETCH = 2'b01;
    localparam logic [1:0] URS_DATEN = 2'b10;
    localparam logic [1:0] URS_ALU   = 2'b11;

    // States that wait on an external completion strobe and are therefore watched.
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_ALU1) || (s == S_ALU) ||
               (s == S_WB_LOAD) || (s == S_WB_STORE);
    endfunction

endpackage

// File: rtl/steuerung_param_zeitueberwachung.sv
// zeitueberwachung: watchdog counter that flags when a wait reaches its limit.
// Latency: expired_o is combinational from the registered count; count updates next edge.
// Backpressure: none; clr_i has priority over en_i, a limit of 0 never expires.
// Ports: Clock/Reset (async, active-high), clr_i, en_i, limit_i[W-1:0], expired_o.
module zeitueberwachung #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The cycle holding limit-1 is the last one allowed; a limit of 0 disables the watch.
    assign expired_o = en_i && (limit_i != '0) && (count_q == (limit_i - 1'b1));

endmodule

// File: rtl/steuerung_param.sv
// steuerung_param: multi-cycle CPU sequencing FSM with watchdog trap, debug halt, optional retire counter.
// Latency: one state step per clock; outputs decode the registered state (jump/JAL terms also gate live class inputs).
// Backpressure: waits on BefehlGeladen/ALUFertig/DatenGeladen/DatenGespeichert, bounded by the watchdog; halt only at instruction boundaries.
// Ports: Clock, Reset (async, active-high); completion strobes; decoded class inputs + Bedingung;
// HaltAnfrage, TrapQuittung; datapath control outputs, TrapSignal, TrapUrsache[1:0], Angehalten, status[3:0].
// Build option: define STEUERUNG_PERF_EN to add the Retired[PERF_W-1:0] retired-instruction counter port.
module steuerung_param
    import steuerung_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200,
    parameter int ALU_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                BefehlGeladen,
    input  logic                DatenGeladen,
    input  logic                DatenGespeichert,
    input  logic                ALUFertig,
    input  logic                LoadBefehl,
    input  logic                StoreBefehl,
    input  logic                JALBefehl,
    input  logic                UnbedingterSprungBefehl,
    input  logic                BedingterSprungBefehl,
    input  logic                Bedingung,
    input  logic                HaltAnfrage,
    input  logic                TrapQuittung,
    output logic                LoadBefehlSignal,
    output logic                DekodierSignal,
    output logic                ALUStartSignal,
    output logic                RegisterSchreibSignal,
    output logic                LoadDatenSignal,
    output logic                StoreDatenSignal,
    output logic                PCSignal,
    output logic                PCSprungSignal,
    output logic                TrapSignal,
    output logic [1:0]          TrapUrsache,
    output logic                Angehalten,
    output logic [STATUS_W-1:0] status
`ifdef STEUERUNG_PERF_EN
    ,
    output logic [PERF_W-1:0]   Retired
`endif
);

    localparam logic [TIMEOUT_W-1:0] MEM_LIM = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] ALU_LIM = TIMEOUT_W'(ALU_TIMEOUT);

    logic [3:0]           state_q, state_d;
    logic [1:0]           ursache_q, ursache_d;
    logic                 fertig;
    logic                 wd_clr, wd_en, wd_expired;
    logic [TIMEOUT_W-1:0] wd_limit;

    // Watchdog: ALU1 is the first cycle of the ALU wait, so ALU1->ALU keeps counting.
    assign wd_en    = is_wait_state(state_q);
    assign wd_limit = ((state_q == S_ALU1) || (state_q == S_ALU)) ? ALU_LIM : MEM_LIM;
    assign wd_clr   = (state_d != state_q) && !((state_q == S_ALU1) && (state_d == S_ALU));

    zeitueberwachung #(
        .W (TIMEOUT_W)
    ) u_zeitueberwachung (
        .Clock     (Clock),
        .Reset     (Reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .limit_i   (wd_limit),
        .expired_o (wd_expired)
    );

    // Next state. Completion strobes are tested before the watchdog so a strobe
    // arriving in the expiry cycle still completes normally.
    always_comb begin
        state_d   = state_q;
        ursache_d = ursache_q;
        fertig    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (BefehlGeladen) begin
                    state_d = S_DECODE;
                end else if (wd_expired) begin
                    state_d   = S_TRAP;
                    ursache_d = URS_FETCH;
                end
            end
            S_DECODE: state_d = S_ALU1;
            S_ALU1, S_ALU: begin
                if (ALUFertig) begin
                    if (UnbedingterSprungBefehl || BedingterSprungBefehl) begin
                        state_d = S_WB_JUMP;
                    end else if (StoreBefehl) begin
                        state_d = S_WB_STORE;
                    end else if (LoadBefehl) begin
                        state_d = S_WB_LOAD;
                    end else begin
                        state_d = S_WB_DEFAULT;
                    end
                end else if (wd_expired) begin
                    state_d   = S_TRAP;
                    ursache_d = URS_ALU;
                end else begin
                    state_d = S_ALU;
                end
            end
            S_WB_JUMP, S_WB_DEFAULT: fertig = 1'b1;
            S_WB_STORE: begin
                if (DatenGespeichert) begin
                    fertig = 1'b1;
                end else if (wd_expired) begin
                    state_d   = S_TRAP;
                    ursache_d = URS_DATEN;
                end
            end
            S_WB_LOAD: begin
                if (DatenGeladen) begin
                    state_d = S_WB_DEFAULT;
                end else if (wd_expired) begin
                    state_d   = S_TRAP;
                    ursache_d = URS_DATEN;
                end
            end
            S_HALT: begin
                if (!HaltAnfrage) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                if (TrapQuittung) begin
                    state_d   = HaltAnfrage ? S_HALT : S_FETCH;
                    ursache_d = URS_NONE;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // Instruction boundary: the only place a pending halt request is honoured.
        if (fertig) begin
            state_d = HaltAnfrage ? S_HALT : S_FETCH;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            ursache_q <= URS_NONE;
        end else begin
            state_q   <= state_d;
            ursache_q <= ursache_d;
        end
    end

`ifdef STEUERUNG_PERF_EN
    logic [PERF_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (fertig) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign Retired = retired_q;
`endif

    assign LoadBefehlSignal      = (state_q == S_FETCH);
    assign DekodierSignal        = (state_q == S_DECODE);
    assign ALUStartSignal        = (state_q == S_ALU1);
    assign LoadDatenSignal       = (state_q == S_WB_LOAD);
    assign StoreDatenSignal      = (state_q == S_WB_STORE);
    assign RegisterSchreibSignal = (((state_q == S_ALU1) || (state_q == S_ALU)) && JALBefehl) ||
                                   (state_q == S_WB_DEFAULT);
    assign PCSignal              = (state_q == S_WB_JUMP) || (state_q == S_WB_STORE) ||
                                   (state_q == S_WB_LOAD) || (state_q == S_WB_DEFAULT);
    assign PCSprungSignal        = (state_q == S_WB_JUMP) &&
                                   (UnbedingterSprungBefehl || (BedingterSprungBefehl && Bedingung));
    assign TrapSignal            = (state_q == S_TRAP);
    assign TrapUrsache           = ursache_q;
    assign Angehalten            = (state_q == S_HALT);
    assign status                = state_q;

endmodule

// File: tb/tb_steuerung_param.sv
module tb_steuerung_param;

    localparam int TW     = 8;
    localparam int MEM_TO = 8;
    localparam int ALU_TO = 6;
    localparam int PW     = 16;

    logic Clock = 1'b0;
    logic Reset;
    logic BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig;
    logic LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung;
    logic HaltAnfrage, TrapQuittung;
    logic LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal;
    logic LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal;
    logic TrapSignal, Angehalten;
    logic [1:0] TrapUrsache;
    logic [3:0] status;
`ifdef STEUERUNG_PERF_EN
    logic [PW-1:0] Retired;
`endif

    steuerung_param #(
        .TIMEOUT_W   (TW),
        .MEM_TIMEOUT (MEM_TO),
        .ALU_TIMEOUT (ALU_TO),
        .PERF_W      (PW)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .BefehlGeladen           (BefehlGeladen),
        .DatenGeladen            (DatenGeladen),
        .DatenGespeichert        (DatenGespeichert),
        .ALUFertig               (ALUFertig),
        .LoadBefehl              (LoadBefehl),
        .StoreBefehl             (StoreBefehl),
        .JALBefehl               (JALBefehl),
        .UnbedingterSprungBefehl (UnbedingterSprungBefehl),
        .BedingterSprungBefehl   (BedingterSprungBefehl),
        .Bedingung               (Bedingung),
        .HaltAnfrage             (HaltAnfrage),
        .TrapQuittung            (TrapQuittung),
        .LoadBefehlSignal        (LoadBefehlSignal),
        .DekodierSignal          (DekodierSignal),
        .ALUStartSignal          (ALUStartSignal),
        .RegisterSchreibSignal   (RegisterSchreibSignal),
        .LoadDatenSignal         (LoadDatenSignal),
        .StoreDatenSignal        (StoreDatenSignal),
        .PCSignal                (PCSignal),
        .PCSprungSignal          (PCSprungSignal),
        .TrapSignal              (TrapSignal),
        .TrapUrsache             (TrapUrsache),
        .Angehalten              (Angehalten),
        .status                  (status)
`ifdef STEUERUNG_PERF_EN
        ,
        .Retired                 (Retired)
`endif
    );

    always #5 Clock = ~Clock;

    wire [11:0] dut_ctrl = {LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal,
                            LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal,
                            TrapSignal, Angehalten, TrapUrsache};

    int checks = 0;
    int errors = 0;

    // Reference model: current phase (numbered as the status codes), cycles already
    // spent in the current wait, latched trap cause, and instructions finished.
    int m_state, m_wait, m_cause, m_retired;

    // Samples taken each cycle by tick(): observed DUT values and model expectations.
    logic [3:0]    o_status, e_status;
    logic [11:0]   o_ctrl, e_ctrl;
    logic [PW-1:0] o_ret, e_ret;

    function automatic logic [11:0] exp_ctrl();
        logic [11:0] v;
        v[11]  = (m_state == 0);
        v[10]  = (m_state == 1);
        v[9]   = (m_state == 2);
        v[8]   = (((m_state == 2) || (m_state == 3)) && JALBefehl) || (m_state == 7);
        v[7]   = (m_state == 6);
        v[6]   = (m_state == 5);
        v[5]   = (m_state >= 4) && (m_state <= 7);
        v[4]   = (m_state == 4) && (UnbedingterSprungBefehl || (BedingterSprungBefehl && Bedingung));
        v[3]   = (m_state == 9);
        v[2]   = (m_state == 8);
        v[1:0] = 2'(m_cause);
        return v;
    endfunction

    // The limit-th cycle of a wait without its strobe times out.
    function automatic bit timed_out(input int lim);
        return (lim != 0) && (m_wait + 1 == lim);
    endfunction

    function automatic int writeback_target();
        if (UnbedingterSprungBefehl || BedingterSprungBefehl) return 4;
        if (StoreBefehl) return 5;
        if (LoadBefehl) return 6;
        return 7;
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_cause = 0; m_retired = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit done;
        nxt  = m_state;
        done = 1'b0;
        case (m_state)
            0: if (BefehlGeladen) nxt = 1;
               else if (timed_out(MEM_TO)) begin nxt = 9; m_cause = 1; end
            1: nxt = 2;
            2, 3: if (ALUFertig) nxt = writeback_target();
                  else if (timed_out(ALU_TO)) begin nxt = 9; m_cause = 3; end
                  else nxt = 3;
            4, 7: done = 1'b1;
            5: if (DatenGespeichert) done = 1'b1;
               else if (timed_out(MEM_TO)) begin nxt = 9; m_cause = 2; end
            6: if (DatenGeladen) nxt = 7;
               else if (timed_out(MEM_TO)) begin nxt = 9; m_cause = 2; end
            8: if (!HaltAnfrage) nxt = 0;
            9: if (TrapQuittung) begin nxt = HaltAnfrage ? 8 : 0; m_cause = 0; end
            default: nxt = 0;
        endcase
        if (done) begin
            nxt = HaltAnfrage ? 8 : 0;
            m_retired++;
        end
        if ((nxt == m_state) || ((m_state == 2) && (nxt == 3))) m_wait++;
        else m_wait = 0;
        m_state = nxt;
    endtask

    task automatic idle();
        BefehlGeladen = 0; DatenGeladen = 0; DatenGespeichert = 0; ALUFertig = 0;
        LoadBefehl = 0; StoreBefehl = 0; JALBefehl = 0;
        UnbedingterSprungBefehl = 0; BedingterSprungBefehl = 0; Bedingung = 0;
        HaltAnfrage = 0; TrapQuittung = 0;
    endtask

    // One clock: sample at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge Clock);
        o_status = status;
        o_ctrl   = dut_ctrl;
        e_status = 4'(m_state);
        e_ctrl   = exp_ctrl();
`ifdef STEUERUNG_PERF_EN
        o_ret = Retired;
`else
        o_ret = '0;
`endif
        e_ret = PW'(m_retired);
        @(posedge Clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1;
        #12;
        checks++;
        if (status !== 4'd0) begin
            errors++; $display("FAIL reset_status: got %0d want 0", status);
        end
        checks++;
        if (dut_ctrl !== 12'b1000_0000_0000) begin
            errors++; $display("FAIL reset_outputs: got %b want 100000000000", dut_ctrl);
        end
`ifdef STEUERUNG_PERF_EN
        checks++;
        if (Retired !== '0) begin
            errors++; $display("FAIL reset_retired: got %0d want 0", Retired);
        end
`endif
        @(posedge Clock);
        #1;
        Reset = 0;
        model_reset();
    endtask

    task automatic test_alu();
        int seq[6] = '{0, 0, 1, 2, 7, 0};
        int rs_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 1) BefehlGeladen = 1;
            if (i == 3) ALUFertig = 1;
            tick();
            checks++;
            if (o_status !== 4'(seq[i])) begin
                errors++; $display("FAIL alu_seq[%0d]: got %0d want %0d", i, o_status, seq[i]);
            end
            checks++;
            if (o_ctrl !== e_ctrl) begin
                errors++; $display("FAIL alu_outputs[%0d]: got %b want %b", i, o_ctrl, e_ctrl);
            end
            if (o_ctrl[8]) rs_cnt++;
        end
        idle();
        checks++;
        if (rs_cnt !== 1) begin
            errors++; $display("FAIL alu_regwrite_cycles: got %0d want 1", rs_cnt);
        end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            int psp_cnt = 0;
            logic pc_in_jump = 1'b0;
            for (int i = 0; i < 5; i++) begin
                idle();
                BedingterSprungBefehl = 1;
                Bedingung = (t == 0);
                if (i == 0) BefehlGeladen = 1;
                if (i == 2) ALUFertig = 1;
                tick();
                checks++;
                if ((o_status !== e_status) || (o_ctrl !== e_ctrl)) begin
                    errors++; $display("FAIL branch_model[%0d/%0d]: got %0d/%b want %0d/%b", t, i, o_status, o_ctrl, e_status, e_ctrl);
                end
                if (o_ctrl[4]) psp_cnt++;
                if (o_status == 4'd4) pc_in_jump = o_ctrl[5];
            end
            checks++;
            if (psp_cnt !== ((t == 0) ? 1 : 0)) begin
                errors++; $display("FAIL branch_pcsprung[%0d]: got %0d cycles want %0d", t, psp_cnt, (t == 0) ? 1 : 0);
            end
            checks++;
            if (pc_in_jump !== 1'b1) begin
                errors++; $display("FAIL branch_pcsignal[%0d]: got %b want 1", t, pc_in_jump);
            end
        end
        idle();
    endtask

    task automatic test_load();
        int load_cnt = 0;
        int traps = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            LoadBefehl = 1;
            if (i == 0) BefehlGeladen = 1;
            if (i == 2) ALUFertig = 1;
            if (i == 7) DatenGeladen = 1;
            tick();
            checks++;
            if ((o_status !== e_status) || (o_ctrl !== e_ctrl)) begin
                errors++; $display("FAIL load_model[%0d]: got %0d/%b want %0d/%b", i, o_status, o_ctrl, e_status, e_ctrl);
            end
            if (o_status == 4'd6) load_cnt++;
            if (o_ctrl[3]) traps++;
        end
        idle();
        checks++;
        if (load_cnt !== 5) begin
            errors++; $display("FAIL load_cycles: got %0d want 5", load_cnt);
        end
        checks++;
        if ((traps !== 0) || (o_status !== 4'd0)) begin
            errors++; $display("FAIL load_end: got traps %0d status %0d want 0 and 0", traps, o_status);
        end
    endtask

    task automatic test_store_timeout();
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            idle();
            StoreBefehl = 1;
            if (i == 0) BefehlGeladen = 1;
            if (i == 2) ALUFertig = 1;
            tick();
        end
        idle();
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if ((o_status !== e_status) || (o_ctrl !== e_ctrl)) begin
                errors++; $display("FAIL store_model[%0d]: got %0d/%b want %0d/%b", k, o_status, o_ctrl, e_status, e_ctrl);
            end
            if (o_status == 4'd5) n++;
            else break;
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL store_wait_cycles: got %0d want 8", n);
        end
        checks++;
        if ((o_status !== 4'd9) || (o_ctrl[1:0] !== 2'b10) || (o_ctrl[3] !== 1'b1)) begin
            errors++; $display("FAIL store_trap: got status %0d cause %b trap %b want 9 10 1", o_status, o_ctrl[1:0], o_ctrl[3]);
        end
        TrapQuittung = 1;
        tick();
        idle();
        tick();
        checks++;
        if ((o_status !== 4'd0) || (o_ctrl[1:0] !== 2'b00) || (o_ctrl[3] !== 1'b0)) begin
            errors++; $display("FAIL trap_ack: got status %0d cause %b trap %b want 0 00 0", o_status, o_ctrl[1:0], o_ctrl[3]);
        end
    endtask

    task automatic test_halt();
        int seq[10] = '{0, 1, 2, 3, 3, 7, 8, 8, 8, 0};
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 0) BefehlGeladen = 1;
            if ((i >= 2) && (i <= 7)) HaltAnfrage = 1;
            if (i == 4) ALUFertig = 1;
            tick();
            checks++;
            if ((o_status !== 4'(seq[i])) || (o_ctrl[2] !== (seq[i] == 8))) begin
                errors++; $display("FAIL halt_seq[%0d]: got status %0d halted %b want %0d %b", i, o_status, o_ctrl[2], seq[i], seq[i] == 8);
            end
            checks++;
            if ((o_status !== e_status) || (o_ctrl !== e_ctrl)) begin
                errors++; $display("FAIL halt_model[%0d]: got %0d/%b want %0d/%b", i, o_status, o_ctrl, e_status, e_ctrl);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            LoadBefehl = 1;
            if (i == 0) BefehlGeladen = 1;
            if (i == 2) ALUFertig = 1;
            tick();
        end
        idle();
        LoadBefehl = 1;
        @(negedge Clock);
        checks++;
        if (status !== 4'd6) begin
            errors++; $display("FAIL areset_pre: got %0d want 6", status);
        end
        #1;
        Reset = 1;
        #1;
        checks++;
        if ((status !== 4'd0) || (dut_ctrl !== 12'b1000_0000_0000)) begin
            errors++; $display("FAIL areset_immediate: got %0d/%b want 0/100000000000", status, dut_ctrl);
        end
`ifdef STEUERUNG_PERF_EN
        checks++;
        if (Retired !== '0) begin
            errors++; $display("FAIL areset_retired: got %0d want 0", Retired);
        end
`endif
        @(posedge Clock);
        #1;
        Reset = 0;
        idle();
        model_reset();
    endtask

`ifdef STEUERUNG_PERF_EN
    task automatic test_retired();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) begin
                idle();
                if (i == 0) BefehlGeladen = 1;
                if (i == 2) ALUFertig = 1;
                tick();
            end
        end
        idle();
        tick();
        checks++;
        if ((o_ret !== PW'(3)) || (o_ret !== e_ret)) begin
            errors++; $display("FAIL retired_three: got %0d want 3 (model %0d)", o_ret, e_ret);
        end
    endtask
`endif

    task automatic test_random();
        int traps_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            BefehlGeladen           = ($urandom_range(0, 9) < 3);
            DatenGeladen            = ($urandom_range(0, 9) < 3);
            DatenGespeichert        = ($urandom_range(0, 9) < 3);
            ALUFertig               = ($urandom_range(0, 9) < 3);
            LoadBefehl              = $urandom_range(0, 1) == 1;
            StoreBefehl             = ($urandom_range(0, 3) == 0);
            JALBefehl               = ($urandom_range(0, 3) == 0);
            UnbedingterSprungBefehl = ($urandom_range(0, 5) == 0);
            BedingterSprungBefehl   = ($urandom_range(0, 5) == 0);
            Bedingung               = $urandom_range(0, 1) == 1;
            HaltAnfrage             = ($urandom_range(0, 19) == 0);
            TrapQuittung            = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if ((o_status !== e_status) || (o_ctrl !== e_ctrl)) begin
                errors++; $display("FAIL random_model[%0d]: got %0d/%b want %0d/%b", i, o_status, o_ctrl, e_status, e_ctrl);
            end
`ifdef STEUERUNG_PERF_EN
            checks++;
            if (o_ret !== e_ret) begin
                errors++; $display("FAIL random_retired[%0d]: got %0d want %0d", i, o_ret, e_ret);
            end
`endif
            if (o_status == 4'd9) traps_seen++;
        end
        idle();
        checks++;
        if (traps_seen == 0) begin
            errors++; $display("FAIL random_trap_coverage: got 0 trap cycles want >0");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store_timeout();
        test_halt();
        test_async_reset();
`ifdef STEUERUNG_PERF_EN
        test_retired();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
